// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller: state encoding,
// regfile port geometry and the checksum rotate helper.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RUN     = 2'd1,
        HALT    = 2'd2,
        TIMEOUT = 2'd3
    } run_state_t;

    localparam int CSUM_ROT   = 5;
    localparam int REG_IDX_W  = 5;
    localparam int REG_DATA_W = 32;

    function automatic logic [REG_DATA_W-1:0] rotl_csum(input logic [REG_DATA_W-1:0] v);
        return {v[REG_DATA_W-1-CSUM_ROT:0], v[REG_DATA_W-1:REG_DATA_W-CSUM_ROT]};
    endfunction

endpackage

// File: rtl/run_controller_halt_detector.sv
// Branch-to-self detector: counts consecutive cycles with an unchanged fetch
// address and flags the cycle on which the run of equal addresses completes.
module halt_detector
    import run_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int HALT_STABLE = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic                  stable
);

    localparam int SW = $clog2(HALT_STABLE);

    logic [ADDR_WIDTH-1:0] prev_addr;
    logic                  prev_valid;
    logic [SW-1:0]         stab_cnt;
    logic [SW-1:0]         stab_next;
    logic                  same;

    // The first enabled cycle has no previous address and counts as a change.
    assign same = prev_valid && (address == prev_addr);

    always_comb begin
        stab_next = '0;
        if (same) begin
            stab_next = (stab_cnt == SW'(HALT_STABLE - 1)) ? stab_cnt : stab_cnt + 1'b1;
        end
    end

    assign stable = enable && (stab_next == SW'(HALT_STABLE - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_addr  <= '0;
            prev_valid <= 1'b0;
            stab_cnt   <= '0;
        end else if (clear) begin
            prev_addr  <= '0;
            prev_valid <= 1'b0;
            stab_cnt   <= '0;
        end else if (enable) begin
            prev_addr  <= address;
            prev_valid <= 1'b1;
            stab_cnt   <= stab_next;
        end
    end

endmodule

// File: rtl/run_controller.sv
// Run controller: sequences processor reset, runs to halt or cycle budget, then
// freezes the processor. Define RUN_CTRL_CHECKSUM_EN to build the write checksum.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int CNT_WIDTH    = 16,
    parameter int RESET_CYCLES = 1,
    parameter int MAX_CYCLES   = 200,
    parameter int HALT_STABLE  = 4,
    parameter int EXIT_REG     = 31
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] address_imem,
    input  logic                  ctrl_writeEnable,
    input  logic [REG_IDX_W-1:0]  ctrl_writeReg,
    input  logic [REG_DATA_W-1:0] data_writeReg,
    output logic                  proc_reset,
    output logic                  running,
    output logic                  done,
    output logic                  halted,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [CNT_WIDTH-1:0]  write_count,
    output logic [ADDR_WIDTH-1:0] halt_pc,
    output logic [REG_DATA_W-1:0] exit_code,
    output logic [REG_DATA_W-1:0] checksum
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    run_state_t           state, state_next;
    logic [HOLD_W-1:0]    hold_cnt;
    logic                 hold_done;
    logic                 in_run;
    logic                 rearm;
    logic                 wr_ok;
    logic                 exit_hit;
    logic                 stable;
    logic                 halt_hit;
    logic                 budget_hit;
    logic [CNT_WIDTH-1:0] cycle_next;

    assign hold_done  = (hold_cnt == HOLD_W'(RESET_CYCLES - 1));
    assign in_run     = (state == RUN);
    assign rearm      = start && ((state == HALT) || (state == TIMEOUT));
    assign wr_ok      = ctrl_writeEnable && (ctrl_writeReg != '0);
    assign exit_hit   = wr_ok && (ctrl_writeReg == REG_IDX_W'(EXIT_REG)) && (data_writeReg != '0);
    assign halt_hit   = stable || exit_hit;
    assign cycle_next = cycle_count + 1'b1;
    assign budget_hit = (cycle_next == CNT_WIDTH'(MAX_CYCLES));

    halt_detector #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .HALT_STABLE (HALT_STABLE)
    ) u_halt_detector (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == HOLD),
        .enable  (in_run),
        .address (address_imem),
        .stable  (stable)
    );

    always_comb begin
        state_next = state;
        case (state)
            HOLD:    if (hold_done) state_next = RUN;
            // Halt takes priority when it coincides with the last budgeted cycle.
            RUN:     if (halt_hit) state_next = HALT;
                     else if (budget_hit) state_next = TIMEOUT;
            HALT,
            TIMEOUT: if (start) state_next = HOLD;
            default: state_next = HOLD;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= HOLD;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            proc_reset <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            proc_reset <= (state_next != RUN);
            running    <= (state_next == RUN);
            done       <= (state_next == HALT) || (state_next == TIMEOUT);
            halted     <= (state_next == HALT);
            timeout    <= (state_next == TIMEOUT);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_cnt    <= '0;
            cycle_count <= '0;
            write_count <= '0;
            halt_pc     <= '0;
            exit_code   <= '0;
        end else if (state == HOLD) begin
            hold_cnt <= hold_done ? '0 : hold_cnt + 1'b1;
        end else if (in_run) begin
            cycle_count <= cycle_next;
            if (wr_ok) write_count <= sat_inc(write_count);
            if (halt_hit) begin
                halt_pc <= address_imem;
                if (exit_hit) exit_code <= data_writeReg;
            end
        end else if (rearm) begin
            hold_cnt    <= '0;
            cycle_count <= '0;
            write_count <= '0;
            halt_pc     <= '0;
            exit_code   <= '0;
        end
    end

`ifdef RUN_CTRL_CHECKSUM_EN
    logic [REG_DATA_W-1:0] csum;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if (in_run && wr_ok) begin
            csum <= rotl_csum(csum) ^ data_writeReg ^ {{(REG_DATA_W-REG_IDX_W){1'b0}}, ctrl_writeReg};
        end else if (rearm) begin
            csum <= '0;
        end
    end

    assign checksum = csum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_run_controller.sv
// Scoreboarded bench for run_controller: directed runs push expected results,
// monitors pop and compare whenever done rises.
module tb_run_controller;

    logic clock;
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        halted;
        logic        timeout;
        logic [15:0] cycles;
        logic [15:0] writes;
        logic [11:0] pc;
        logic [31:0] exit_code;
        logic [31:0] csum;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    // DUT A: default parameters
    logic        reset_a, start_a, we_a;
    logic [11:0] addr_a;
    logic [4:0]  wreg_a;
    logic [31:0] wdata_a;
    logic        prst_a, run_a, done_a, halt_a, tmo_a;
    logic [15:0] cyc_a, wc_a;
    logic [11:0] hpc_a;
    logic [31:0] exit_a, csum_a;

    // DUT B: short budget
    logic        reset_b, start_b, we_b;
    logic [11:0] addr_b;
    logic [4:0]  wreg_b;
    logic [31:0] wdata_b;
    logic        prst_b, run_b, done_b, halt_b, tmo_b;
    logic [15:0] cyc_b, wc_b;
    logic [11:0] hpc_b;
    logic [31:0] exit_b, csum_b;

    run_controller dut_a (
        .clock(clock), .reset(reset_a), .start(start_a), .address_imem(addr_a),
        .ctrl_writeEnable(we_a), .ctrl_writeReg(wreg_a), .data_writeReg(wdata_a),
        .proc_reset(prst_a), .running(run_a), .done(done_a), .halted(halt_a),
        .timeout(tmo_a), .cycle_count(cyc_a), .write_count(wc_a), .halt_pc(hpc_a),
        .exit_code(exit_a), .checksum(csum_a)
    );

    run_controller #(.MAX_CYCLES(8)) dut_b (
        .clock(clock), .reset(reset_b), .start(start_b), .address_imem(addr_b),
        .ctrl_writeEnable(we_b), .ctrl_writeReg(wreg_b), .data_writeReg(wdata_b),
        .proc_reset(prst_b), .running(run_b), .done(done_b), .halted(halt_b),
        .timeout(tmo_b), .cycle_count(cyc_b), .write_count(wc_b), .halt_pc(hpc_b),
        .exit_code(exit_b), .checksum(csum_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic check_result(input string tag, input exp_t e, input logic h, input logic t,
                                input logic [15:0] c, input logic [15:0] w, input logic [11:0] p,
                                input logic [31:0] x, input logic [31:0] s);
        check({tag, "_halted"},  32'(h), 32'(e.halted));
        check({tag, "_timeout"}, 32'(t), 32'(e.timeout));
        check({tag, "_cycles"},  32'(c), 32'(e.cycles));
        check({tag, "_writes"},  32'(w), 32'(e.writes));
        check({tag, "_halt_pc"}, 32'(p), 32'(e.pc));
        check({tag, "_exit"},    x, e.exit_code);
        check({tag, "_csum"},    s, e.csum);
    endtask

    task automatic push_a(input logic h, input logic t, input logic [15:0] c, input logic [15:0] w,
                          input logic [11:0] p, input logic [31:0] x, input logic [31:0] s);
        exp_t e;
        e.halted = h; e.timeout = t; e.cycles = c; e.writes = w;
        e.pc = p; e.exit_code = x; e.csum = s;
        exp_a.push_back(e);
    endtask

    task automatic push_b(input logic h, input logic t, input logic [15:0] c, input logic [15:0] w,
                          input logic [11:0] p, input logic [31:0] x, input logic [31:0] s);
        exp_t e;
        e.halted = h; e.timeout = t; e.cycles = c; e.writes = w;
        e.pc = p; e.exit_code = x; e.csum = s;
        exp_b.push_back(e);
    endtask

    task automatic step_a(input logic [11:0] a, input logic we, input logic [4:0] r,
                          input logic [31:0] d, input logic st);
        addr_a = a; we_a = we; wreg_a = r; wdata_a = d; start_a = st;
        @(posedge clock);
        #1;
    endtask

    task automatic step_b(input logic [11:0] a, input logic we, input logic [4:0] r,
                          input logic [31:0] d, input logic st);
        addr_b = a; we_b = we; wreg_b = r; wdata_b = d; start_b = st;
        @(posedge clock);
        #1;
    endtask

    // Monitors: one result per rising edge of done
    initial begin : mon_a
        exp_t e;
        logic seen;
        seen = 1'b0;
        forever begin
            @(negedge clock);
            if (done_a === 1'b1 && !seen) begin
                if (exp_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected_done: got done=1 required no result pending");
                end else begin
                    e = exp_a.pop_front();
                    check_result("a", e, halt_a, tmo_a, cyc_a, wc_a, hpc_a, exit_a, csum_a);
                end
            end
            seen = (done_a === 1'b1);
        end
    end

    initial begin : mon_b
        exp_t e;
        logic seen;
        seen = 1'b0;
        forever begin
            @(negedge clock);
            if (done_b === 1'b1 && !seen) begin
                if (exp_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected_done: got done=1 required no result pending");
                end else begin
                    e = exp_b.pop_front();
                    check_result("b", e, halt_b, tmo_b, cyc_b, wc_b, hpc_b, exit_b, csum_b);
                end
            end
            seen = (done_b === 1'b1);
        end
    end

`ifdef RUN_CTRL_CHECKSUM_EN
    localparam logic [31:0] CS_EXIT  = 32'h0000_00B5;
    localparam logic [31:0] CS_MID   = 32'h0000_0011;
    localparam logic [31:0] CS_B     = 32'h0000_0086;
`else
    localparam logic [31:0] CS_EXIT  = 32'h0;
    localparam logic [31:0] CS_MID   = 32'h0;
    localparam logic [31:0] CS_B     = 32'h0;
`endif

    initial begin
        reset_a = 1'b1; start_a = 1'b0; addr_a = '0; we_a = 1'b0; wreg_a = '0; wdata_a = '0;
        reset_b = 1'b1; start_b = 1'b0; addr_b = '0; we_b = 1'b0; wreg_b = '0; wdata_b = '0;
        repeat (3) @(posedge clock);
        #1;

        // Reset state
        check("rst_flags", 32'({prst_a, run_a, done_a, halt_a, tmo_a}), 32'b10000);
        check("rst_cycles", 32'(cyc_a), 0);
        check("rst_writes", 32'(wc_a), 0);
        check("rst_capture", exit_a | 32'(hpc_a) | csum_a, 0);

        // Run 1: incrementing address, no writes -> timeout at 200
        reset_a = 1'b0;
        push_a(1'b0, 1'b1, 16'd200, 16'd0, 12'd0, 32'h0, 32'h0);
        check("t1_prst_hold", 32'(prst_a), 1);
        step_a(12'd0, 1'b0, 5'd0, 32'h0, 1'b0);
        check("t1_prst_released", 32'(prst_a), 0);
        check("t1_running", 32'(run_a), 1);
        for (int i = 0; i < 199; i++) step_a(12'(i + 1), 1'b0, 5'd0, 32'h0, 1'b0);
        check("t1_not_done_199", 32'(done_a), 0);
        check("t1_cycles_199", 32'(cyc_a), 199);
        step_a(12'd200, 1'b0, 5'd0, 32'h0, 1'b0);
        check("t1_done_flags", 32'({prst_a, run_a, done_a}), 32'b101);

        // Run 2: start re-arms; address 0,1,2,3,3,3,3 -> halt at 3
        step_a(12'd0, 1'b0, 5'd0, 32'h0, 1'b1);
        check("t2_cleared_flags", 32'({prst_a, run_a, done_a, halt_a, tmo_a}), 32'b10000);
        check("t2_cleared_cycles", 32'(cyc_a), 0);
        push_a(1'b1, 1'b0, 16'd7, 16'd0, 12'd3, 32'h0, 32'h0);
        step_a(12'd0, 1'b0, 5'd0, 32'h0, 1'b0);
        check("t2_prst_released", 32'(prst_a), 0);
        begin
            logic [11:0] seq [7];
            seq = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd3, 12'd3, 12'd3};
            for (int i = 0; i < 7; i++) begin
                step_a(seq[i], 1'b0, 5'd0, 32'h0, 1'b0);
                if (i == 5) check("t2_not_done_3_equal", 32'(done_a), 0);
            end
        end
        check("t2_halted", 32'(halt_a), 1);
        // Writes in the done state are ignored
        step_a(12'd5, 1'b1, 5'd3, 32'h55, 1'b0);
        check("t2_hold_writes", 32'(wc_a), 0);
        check("t2_hold_pc", 32'(hpc_a), 3);
        check("t2_hold_cycles", 32'(cyc_a), 7);

        // Run 3: r0=5 (ignored), r3=7, start in RUN (ignored), r31=0x2A at cycle 10
        step_a(12'd0, 1'b0, 5'd0, 32'h0, 1'b1);
        step_a(12'd0, 1'b0, 5'd0, 32'h0, 1'b0);
        push_a(1'b1, 1'b0, 16'd10, 16'd2, 12'd10, 32'h2A, CS_EXIT);
        for (int i = 1; i <= 10; i++) begin
            case (i)
                2:       step_a(12'(i), 1'b1, 5'd0,  32'h5,  1'b0);
                4:       step_a(12'(i), 1'b1, 5'd3,  32'h7,  1'b0);
                6:       step_a(12'(i), 1'b0, 5'd0,  32'h0,  1'b1);
                10:      step_a(12'(i), 1'b1, 5'd31, 32'h2A, 1'b0);
                default: step_a(12'(i), 1'b0, 5'd0,  32'h0,  1'b0);
            endcase
            if (i == 9) begin
                check("t3_writes_before_exit", 32'(wc_a), 1);
                check("t3_still_running", 32'(run_a), 1);
            end
        end

        // Run 4: checksum sequence r1=1, r2=2, r1=0x10, then stable halt
        step_a(12'd0, 1'b0, 5'd0, 32'h0, 1'b1);
        step_a(12'd0, 1'b0, 5'd0, 32'h0, 1'b0);
        push_a(1'b1, 1'b0, 16'd7, 16'd3, 12'd3, 32'h0, CS_MID);
        step_a(12'd0, 1'b1, 5'd1, 32'h1, 1'b0);
        step_a(12'd1, 1'b1, 5'd2, 32'h2, 1'b0);
        check("t4_csum_zero", csum_a, 32'h0);
        step_a(12'd2, 1'b1, 5'd1, 32'h10, 1'b0);
        check("t4_csum_mid", csum_a, CS_MID);
        for (int i = 0; i < 4; i++) step_a(12'd3, 1'b0, 5'd0, 32'h0, 1'b0);

        // Run 5: reset asserted mid-run
        step_a(12'd0, 1'b0, 5'd0, 32'h0, 1'b1);
        step_a(12'd0, 1'b0, 5'd0, 32'h0, 1'b0);
        step_a(12'd0, 1'b1, 5'd4, 32'h9, 1'b0);
        step_a(12'd1, 1'b0, 5'd0, 32'h0, 1'b0);
        step_a(12'd2, 1'b0, 5'd0, 32'h0, 1'b0);
        check("t5_cycles_before_reset", 32'(cyc_a), 3);
        reset_a = 1'b1;
        #1;
        check("t5_async_flags", 32'({prst_a, run_a, done_a, halt_a, tmo_a}), 32'b10000);
        check("t5_async_counts", 32'({cyc_a, wc_a}), 0);
        step_a(12'd0, 1'b0, 5'd0, 32'h0, 1'b0);

        // DUT B: exit write in the last budgeted cycle -> halt wins
        reset_b = 1'b0;
        step_b(12'd0, 1'b0, 5'd0, 32'h0, 1'b0);
        push_b(1'b1, 1'b0, 16'd8, 16'd1, 12'd7, 32'h99, CS_B);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) step_b(12'(i), 1'b1, 5'd31, 32'h99, 1'b0);
            else        step_b(12'(i), 1'b0, 5'd0,  32'h0,  1'b0);
        end
        check("b_tie_timeout_low", 32'(tmo_b), 0);

        // DUT B: plain budget exhaustion at 8
        step_b(12'd0, 1'b0, 5'd0, 32'h0, 1'b1);
        step_b(12'd0, 1'b0, 5'd0, 32'h0, 1'b0);
        push_b(1'b0, 1'b1, 16'd8, 16'd0, 12'd0, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) step_b(12'(i + 1), 1'b0, 5'd0, 32'h0, 1'b0);

        repeat (3) @(posedge clock);
        #1;
        check("a_results_pending", 32'(exp_a.size()), 0);
        check("b_results_pending", 32'(exp_b.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Synthesizable run-control block that replaces fixed-length, hand-sequenced processor test runs.
- Sequences processor reset for a parametrised number of cycles, then lets the processor run. Tracks the cycle budget and regfile writes.
- Ends the run on a detected halt (branch-to-self or exit-register write) or on timeout, then freezes the processor in reset.
- Sits between the top-level clock/reset and the processor skeleton; passively observes the imem address and regfile write ports.

Parameters:
- ADDR_WIDTH, 12, width of address_imem / halt_pc.
- CNT_WIDTH, 16, width of cycle_count and write_count; MAX_CYCLES must be < 2^CNT_WIDTH.
- RESET_CYCLES, 1, cycles proc_reset is held after reset release or start; must be >= 1.
- MAX_CYCLES, 200, run-cycle budget before timeout; must be >= 1.
- HALT_STABLE, 4, consecutive run cycles with an unchanged address_imem that count as halt; must be >= 2.
- EXIT_REG, 31, regfile index whose nonzero write ends the run.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; re-arms a finished run.
- address_imem  in  ADDR_WIDTH  processor fetch address.
- ctrl_writeEnable  in  1  regfile write strobe.
- ctrl_writeReg  in  5  regfile write index.
- data_writeReg  in  32  regfile write data.
- proc_reset  out  1  reset to processor.
- running  out  1  high in RUN.
- done  out  1  run finished (halt or timeout).
- halted  out  1  finished by halt.
- timeout  out  1  finished by budget exhaustion.
- cycle_count  out  CNT_WIDTH  RUN cycles elapsed.
- write_count  out  CNT_WIDTH  qualifying regfile writes.
- halt_pc  out  ADDR_WIDTH  address at halt.
- exit_code  out  32  data of the EXIT_REG write, else 0.
- checksum  out  32  write signature (optional feature).

Behaviour:
- Reset (async, high): state HOLD.
  - proc_reset=1; running=done=halted=timeout=0.
  - All counters, halt_pc, exit_code and checksum are 0.
- All outputs are registered.
- HOLD:
  - hold counter increments each cycle.
  - After RESET_CYCLES cycles in HOLD, go to RUN; proc_reset=0 from that edge.
  - proc_reset is therefore high for exactly RESET_CYCLES clocks after reset release.
- RUN, each cycle:
  - cycle_count += 1.
  - A write with ctrl_writeEnable=1 and ctrl_writeReg != 0 increments write_count. Writes to r0 are ignored everywhere.
  - Stability counter: 0 when address_imem differs from the previous cycle's value, +1 when equal.
  - The first RUN cycle compares against no prior value and so counts as "differs".
- Halt conditions (HALT):
  - The stability counter reaches HALT_STABLE-1, i.e. the address is equal for HALT_STABLE consecutive cycles; or
  - a write to EXIT_REG with nonzero data_writeReg. exit_code captures that data.
  - On halt, halt_pc captures the current address_imem.
- Timeout: cycle_count reaching MAX_CYCLES on this edge -> TIMEOUT.
- Simultaneous halt and timeout on the same edge: HALT wins (halted=1, timeout=0).
- A halt-causing write in the final cycle is still counted in write_count.
- HALT / TIMEOUT (done=1, running=0, proc_reset=1):
  - Counters and captures hold their values.
  - Inputs other than start are ignored.
- start=1 in HALT/TIMEOUT: clears counters, captures, flags and checksum next edge; enters HOLD. start is ignored in HOLD and RUN.
- cycle_count never exceeds MAX_CYCLES. write_count saturates at all-ones.
- Reset asserted mid-run: immediate return to HOLD with all outputs at reset values.

Optional Feature:
- Macro RUN_CTRL_CHECKSUM_EN.
- With the macro: in RUN, each qualifying write updates checksum = rotl(checksum,5) ^ data_writeReg ^ {27'b0, ctrl_writeReg}. This includes the final halting write. checksum is cleared by reset/start and held in the done states.
- Without the macro: checksum is tied to 32'h0 and no accumulator logic is built.

Decomposition:
- Package run_ctrl_pkg:
  - state encoding localparams: HOLD=2'd0, RUN=2'd1, HALT=2'd2, TIMEOUT=2'd3;
  - checksum rotate amount (5);
  - regfile index width (5) and data width (32).
- Sub-module halt_detector (ADDR_WIDTH, HALT_STABLE):
  - previous-address register, stability counter, and a "stable" output;
  - cleared by reset and by a clear input driven in HOLD.

Test Plan:
- Defaults; release reset; address_imem increments every cycle, no writes -> proc_reset high exactly 1 cycle; timeout=1, halted=0, cycle_count=200, then proc_reset=1, done=1.
- address_imem steps 0,1,2,3 then holds 3 -> halted=1, halt_pc=3 after the 4th consecutive cycle at 3; cycle_count equals the RUN cycles elapsed.
- Write r31=32'h0000_002A at cycle 10, plus writes r0=5 and r3=7 earlier -> halted=1, exit_code=32'h2A, write_count=2 (r3 and r31); r0 not counted.
- MAX_CYCLES=8, exit write in the 8th RUN cycle -> halted=1, timeout=0.
- After a finished run, pulse start -> outputs cleared, proc_reset high RESET_CYCLES cycles, new run proceeds. Assert reset mid-RUN -> immediate reset values.
- With RUN_CTRL_CHECKSUM_EN: writes r1=1 then r2=2 -> checksum = rotl(1^1,5)^2^2 = 0. Then r1=32'h10 -> checksum = 32'h11. Without the macro, checksum stays 0.
